jtag_master: RTL
================

Name: jtag_master

Overview:
- Bit-banged JTAG initiator clocked from the system clock.
- Drives TCK/TMS/TDI and samples TDO, so the FPGA can act as the host for a TAP such as the jtag_gpios virtual-JTAG target. This enables loopback test of the target with no external cable.
- Accepts one command at a time (TAP reset, IR shift, DR shift, idle clocks) over a valid/ready interface and returns the captured TDO bits with a one-cycle response pulse.

Parameters:
- CLK_DIV, 4: clk cycles per TCK half-period. Minimum 1.
- MAX_BITS, 32: maximum shift length per command.
- LEN_BITS, $clog2(MAX_BITS+1): width of cmd_len. Derived; do not override.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block idle and able to accept a command.
- cmd_type  input  2  0 = TAP reset, 1 = shift IR, 2 = shift DR, 3 = idle clocks.
- cmd_len  input  LEN_BITS  number of bits to shift, or number of idle TCK cycles.
- cmd_data  input  MAX_BITS  TDI bits, LSB shifted first.
- rsp_valid  output  1  one-cycle pulse when the command completes.
- rsp_data  output  MAX_BITS  captured TDO bits, LSB first.
- jtag_tck  output  1  JTAG TCK.
- jtag_tms  output  1  JTAG TMS.
- jtag_tdi  output  1  JTAG TDI.
- jtag_tdo  input  1  JTAG TDO. Synchronised internally with 2 flops.

Behaviour:
- Reset values:
  - jtag_tck = 0, jtag_tms = 1, jtag_tdi = 0.
  - cmd_ready = 0, rsp_valid = 0, rsp_data = 0.
- TCK cycle:
  - Low phase of CLK_DIV clk cycles, then high phase of CLK_DIV clk cycles.
  - TMS and TDI update only on the first clk of the low phase (TCK falling edge).
  - The synchronised TDO is sampled on the last clk of the high phase.
- Post-reset init: once reset deasserts, the block automatically runs 5 TCK cycles with TMS = 1, then 1 with TMS = 0, ending in Run-Test/Idle. cmd_ready stays 0 until the init sequence completes. No rsp_valid is produced for init.
- Command handshake:
  - A command is accepted when cmd_valid && cmd_ready; cmd_ready drops the next cycle.
  - cmd_type, cmd_len and cmd_data are registered at acceptance.
  - The first low phase starts the cycle after acceptance.
- TAP state: every command starts and ends in Run-Test/Idle.
- TMS sequences per command:
  - TAP reset: 1,1,1,1,1,0 (6 TCK cycles).
  - Shift DR: 1,0,0, then N data cycles with TMS = 0 except TMS = 1 on the last, then 1,0. Total N+5 TCK cycles.
  - Shift IR: 1,1,0,0, then N data cycles as for DR, then 1,0. Total N+6 TCK cycles.
  - Idle clocks: N TCK cycles with TMS = 0.
- Data phase:
  - jtag_tdi = cmd_data[i] during data cycle i.
  - jtag_tdi = 0 outside data cycles.
  - rsp_data[i] = TDO sampled in data cycle i; bits at index N and above are 0.
  - For TAP reset and idle commands, rsp_data = 0.
- Completion:
  - rsp_valid pulses for 1 clk on the cycle after the final high phase ends; jtag_tck is 0 at that point.
  - cmd_ready returns to 1 on the same cycle.
  - rsp_data holds its value until the next completion.
- Boundary conditions:
  - cmd_len = 0: no TCK toggles for any command type except TAP reset, which always runs its 6 cycles. rsp_valid follows 1 cycle after acceptance, with rsp_data = 0.
  - cmd_len > MAX_BITS: clamped to MAX_BITS.
  - cmd_valid while busy: ignored and not lost. The command is held by the upstream until cmd_ready.
  - Back-to-back commands: a command presented on the rsp_valid cycle is accepted that cycle; its first low phase starts the next cycle.
  - Reset mid-command: all outputs return to reset values immediately, the command is abandoned with no rsp_valid, and the init sequence reruns.
- Counters:
  - Divider counts 0..CLK_DIV-1 per phase.
  - Bit counter is LEN_BITS wide and counts down from N to 1.

Test Plan:
- Reset then release, CLK_DIV = 2: jtag_tms = 1 for exactly 5 TCK rising edges, then 0 for 1. cmd_ready rises 24 clk after release. No rsp_valid.
- Shift DR, len = 8, data = 0xA5, TDO looped from TDI: 13 TCK cycles; TDI bit sequence 1,0,1,0,0,1,0,1; TMS = 1 only on the 8th data cycle and the first post-data cycle; rsp_data = 0xA5; rsp_valid pulses once.
- Shift IR, len = 4, data = 0x3, TDO tied 1: TMS sequence 1,1,0,0,0,0,0,1,1,0; rsp_data = 0xF.
- Idle clocks, len = 3: 3 TCK pulses with TMS = 0 and TDI = 0; rsp_data = 0.
- Shift DR, len = 0: no TCK edges; rsp_valid pulses 1 clk after acceptance.
- Reset asserted during data cycle 5 of a 32-bit DR shift: outputs reach reset values next cycle, no rsp_valid, init sequence restarts, and a subsequent command completes normally.

Source files
------------

// File: rtl/jtag_master.sv
// Bit-banged JTAG initiator: runs TAP reset, IR/DR shifts and idle clocks,
// always starting and ending in Run-Test/Idle, and returns the captured TDO bits.
module jtag_master #(
    parameter int CLK_DIV  = 4,
    parameter int MAX_BITS = 32,
    parameter int LEN_BITS = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_type,
    input  logic [LEN_BITS-1:0] cmd_len,
    input  logic [MAX_BITS-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                jtag_tck,
    output logic                jtag_tms,
    output logic                jtag_tdi,
    input  logic                jtag_tdo
);

    // state   | meaning
    // ST_IDLE | parked in Run-Test/Idle, accepting commands
    // ST_PRE  | TMS preamble (post-reset init, TAP reset, walk to Shift-IR/DR)
    // ST_DATA | shifting data bits, or free-running idle clocks
    // ST_POST | Exit1 -> Update -> Run-Test/Idle
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_POST = 2'd3;

    localparam logic [1:0] CMD_RESET = 2'd0;
    localparam logic [1:0] CMD_IR    = 2'd1;
    localparam logic [1:0] CMD_DR    = 2'd2;
    localparam logic [1:0] CMD_IDLE  = 2'd3;

    localparam int                  DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LEN_BITS-1:0] LEN_MAX  = LEN_BITS'(MAX_BITS);

    // Preamble TMS patterns, consumed LSB first.
    localparam logic [5:0] PAT_RESET = 6'b011111;
    localparam logic [5:0] PAT_IR    = 6'b000011;
    localparam logic [5:0] PAT_DR    = 6'b000001;

    logic [1:0]          state, state_n;
    logic [DIV_W-1:0]    div, div_n;
    logic [5:0]          pre_pat, pre_pat_n;
    logic [2:0]          pre_cnt, pre_cnt_n;
    logic [LEN_BITS-1:0] bit_cnt, bit_cnt_n, len_clamp;
    logic                post_first, post_first_n;
    logic                idle_cmd, idle_cmd_n;
    logic                has_post, has_post_n;
    logic                respond, respond_n;
    logic [MAX_BITS-1:0] tdi_sr, tdi_sr_n;
    logic [MAX_BITS-1:0] cap, cap_n, cap_mask, cap_mask_n;
    logic [MAX_BITS-1:0] rsp_data_n;
    logic                rsp_valid_n, tck_n, tms_n, tdi_n;
    logic                tdo_meta, tdo_sync;
    logic                finish;

    assign cmd_ready = (state == ST_IDLE);
    assign len_clamp = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;

    always_comb begin
        state_n      = state;
        div_n        = div;
        tck_n        = jtag_tck;
        pre_pat_n    = pre_pat;
        pre_cnt_n    = pre_cnt;
        bit_cnt_n    = bit_cnt;
        post_first_n = post_first;
        idle_cmd_n   = idle_cmd;
        has_post_n   = has_post;
        respond_n    = respond;
        tdi_sr_n     = tdi_sr;
        cap_n        = cap;
        cap_mask_n   = cap_mask;
        rsp_valid_n  = 1'b0;
        rsp_data_n   = rsp_data;
        finish       = 1'b0;

        if (state == ST_IDLE) begin
            if (cmd_valid) begin
                div_n        = '0;
                tck_n        = 1'b0;
                tdi_sr_n     = cmd_data;
                cap_n        = '0;
                cap_mask_n   = MAX_BITS'(1);
                post_first_n = 1'b0;
                respond_n    = 1'b1;
                idle_cmd_n   = (cmd_type == CMD_IDLE);
                has_post_n   = (cmd_type == CMD_IR) || (cmd_type == CMD_DR);
                bit_cnt_n    = len_clamp;
                case (cmd_type)
                    CMD_RESET: begin
                        pre_pat_n = PAT_RESET;
                        pre_cnt_n = 3'd6;
                        bit_cnt_n = '0;
                        state_n   = ST_PRE;
                    end
                    CMD_IR: begin
                        pre_pat_n = PAT_IR;
                        pre_cnt_n = 3'd4;
                        state_n   = (len_clamp == '0) ? ST_IDLE : ST_PRE;
                    end
                    CMD_DR: begin
                        pre_pat_n = PAT_DR;
                        pre_cnt_n = 3'd3;
                        state_n   = (len_clamp == '0) ? ST_IDLE : ST_PRE;
                    end
                    default: begin
                        pre_cnt_n = 3'd0;
                        state_n   = (len_clamp == '0) ? ST_IDLE : ST_DATA;
                    end
                endcase
                // Zero-length shifts and idles complete without touching TCK.
                if (state_n == ST_IDLE) begin
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = '0;
                end
            end
        end else if (div != DIV_LAST) begin
            div_n = div + 1'b1;
        end else begin
            div_n = '0;
            tck_n = ~jtag_tck;
            if (jtag_tck) begin
                case (state)
                    ST_PRE: begin
                        if (pre_cnt > 3'd1) begin
                            pre_cnt_n = pre_cnt - 1'b1;
                            pre_pat_n = pre_pat >> 1;
                        end else if (bit_cnt != '0) begin
                            state_n = ST_DATA;
                        end else begin
                            finish = 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (!idle_cmd) begin
                            cap_n      = cap | (cap_mask & {MAX_BITS{tdo_sync}});
                            cap_mask_n = cap_mask << 1;
                        end
                        if (bit_cnt > LEN_BITS'(1)) begin
                            bit_cnt_n = bit_cnt - 1'b1;
                            tdi_sr_n  = tdi_sr >> 1;
                        end else if (has_post) begin
                            state_n      = ST_POST;
                            post_first_n = 1'b1;
                        end else begin
                            finish = 1'b1;
                        end
                    end
                    ST_POST: begin
                        if (post_first) post_first_n = 1'b0;
                        else            finish       = 1'b1;
                    end
                    default: finish = 1'b1;
                endcase
                if (finish) begin
                    state_n = ST_IDLE;
                    if (respond) begin
                        rsp_valid_n = 1'b1;
                        rsp_data_n  = cap_n;
                    end
                end
            end
        end

        // Pins follow the descriptors of the TCK cycle about to start, so they
        // only move on the edge that opens a low phase.
        case (state_n)
            ST_PRE:  tms_n = pre_pat_n[0];
            ST_DATA: tms_n = !idle_cmd_n && (bit_cnt_n == LEN_BITS'(1));
            ST_POST: tms_n = post_first_n;
            default: tms_n = 1'b0;
        endcase
        tdi_n = (state_n == ST_DATA) && !idle_cmd_n && tdi_sr_n[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_PRE;
            div        <= '0;
            pre_pat    <= PAT_RESET;
            pre_cnt    <= 3'd6;
            bit_cnt    <= '0;
            post_first <= 1'b0;
            idle_cmd   <= 1'b0;
            has_post   <= 1'b0;
            respond    <= 1'b0;
            tdi_sr     <= '0;
            cap        <= '0;
            cap_mask   <= MAX_BITS'(1);
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            jtag_tck   <= 1'b0;
            jtag_tms   <= 1'b1;
            jtag_tdi   <= 1'b0;
            tdo_meta   <= 1'b0;
            tdo_sync   <= 1'b0;
        end else begin
            state      <= state_n;
            div        <= div_n;
            pre_pat    <= pre_pat_n;
            pre_cnt    <= pre_cnt_n;
            bit_cnt    <= bit_cnt_n;
            post_first <= post_first_n;
            idle_cmd   <= idle_cmd_n;
            has_post   <= has_post_n;
            respond    <= respond_n;
            tdi_sr     <= tdi_sr_n;
            cap        <= cap_n;
            cap_mask   <= cap_mask_n;
            rsp_valid  <= rsp_valid_n;
            rsp_data   <= rsp_data_n;
            jtag_tck   <= tck_n;
            jtag_tms   <= tms_n;
            jtag_tdi   <= tdi_n;
            tdo_meta   <= jtag_tdo;
            tdo_sync   <= tdo_meta;
        end
    end

endmodule
